// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package reg_file_pkg;
   localparam int WORD_W     = `WORD_SIZE;
   localparam int REG_ADDR_W = 5;

   typedef logic [WORD_W-1:0]     word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/definitions.sv
// Global core-wide sizing macros shared by the MIPS pipeline blocks.
`ifndef DEFINITIONS_SV
`define DEFINITIONS_SV
`define WORD_SIZE 32
`endif

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard: issue marks a destination pending, writeback clears it.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_WR   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   output logic [NUM_REGS-1:0]      busy_vec
);

   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] busy_q;

   // R0 can never be set, so its busy bit stays at its reset value of zero
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_en) set_vec[iss_addr] = 1'b1;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j]) clr_vec[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
      set_vec[ADDR_W'(REG_ZERO)] = 1'b0;
   end

   // A new producer issued in the same cycle as a writeback keeps the register busy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_q <= '0;
      else       busy_q <= set_vec | (busy_q & ~clr_vec);
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional write-to-read bypass and busy scoreboard.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int DATA_W   = WORD_W,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic [NUM_REGS-1:0]      busy_vec,
   output logic                     wr_conflict
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [ADDR_W-1:0] wa   [NUM_WR];
   logic [DATA_W-1:0] wd   [NUM_WR];
   logic              conflict_now;
   logic              conflict_q;

   for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
      assign wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
      assign wd[j] = wr_data[j*DATA_W +: DATA_W];
   end

   // Ports are applied in ascending order so the highest-index port wins a collision
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && wa[j] != ZERO_ADDR) regs[wa[j]] <= wd[j];
         end
      end
   end

   always_comb begin
      conflict_now = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (wr_en[i] && wr_en[j] && wa[i] == wa[j] && wa[i] != ZERO_ADDR)
               conflict_now = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) conflict_q <= 1'b0;
      else       conflict_q <= conflict_q | conflict_now;
   end

   assign wr_conflict = conflict_q;

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .busy_vec (busy_vec)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] val;
      logic              hit;

      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

      // Bypass data is valid right now, so a hitting read no longer needs to stall
      always_comb begin
         val = regs[ra];
         hit = 1'b0;
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && wa[j] == ra) begin
                  val = wd[j];
                  hit = 1'b1;
               end
            end
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = (reset || ra == ZERO_ADDR) ? '0 : val;
      assign rd_busy[k] = !reset && ra != ZERO_ADDR && busy_vec[ra] && !hit;
   end

endmodule
